// File: rtl/fp_pkg.sv
// fp_pkg: shared single-precision float constants and converter state type.
package fp_pkg;
    localparam int FP_EXP_W = 8;
    localparam int FP_MAN_W = 23;
    localparam int FP_BIAS = 127;
    localparam logic [FP_EXP_W-1:0] FP_INT_EXP0 = 8'd158;
    localparam logic [31:0] FP_ZERO = 32'h0;
    typedef enum logic [1:0] {IDLE, LOAD, NORM, ROUND} fp_state_t;
endpackage

// File: rtl/fp_round_ne.sv
// fp_round_ne: packs a normalized 32-bit magnitude into a single, rounding to nearest-even.
module fp_round_ne
    import fp_pkg::*;
(
    input  logic [31:0]         mag,
    input  logic                sign,
    input  logic [FP_EXP_W-1:0] exp,
    output logic [31:0]         result
);
    logic                inc;
    logic [FP_MAN_W:0]   man_r;
    logic [FP_EXP_W-1:0] exp_r;
    assign inc = mag[7] & ((|mag[6:0]) | mag[8]);
    assign man_r = {1'b0, mag[30:8]} + {{FP_MAN_W{1'b0}}, inc};
    // a carry out of the mantissa leaves it all-zero and bumps the exponent
    assign exp_r = exp + {{(FP_EXP_W-1){1'b0}}, man_r[FP_MAN_W]};
    assign result = {sign, exp_r, man_r[FP_MAN_W-1:0]};
endmodule

// File: rtl/fp_int_to_float.sv
// fp_int_to_float: multi-cycle 32-bit integer to IEEE-754 single converter,
// normalizing one bit per clock and holding the result for the fp_result PIO.
module fp_int_to_float
    import fp_pkg::*;
#(
    parameter logic SIGNED_IN = 1'b1,
    parameter logic ZERO_FAST = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] data_in,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic        result_valid
);
    fp_state_t           state;
    logic [31:0]         mag;
    logic [FP_EXP_W-1:0] exp;
    logic                sign;
    logic                zero;
    logic                neg;
    logic [31:0]         abs_mag;
    logic [31:0]         rounded;
    assign neg = SIGNED_IN & mag[31];
    assign abs_mag = neg ? -mag : mag;
    fp_round_ne u_round (
        .mag    (mag),
        .sign   (sign),
        .exp    (exp),
        .result (rounded)
    );
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            mag          <= '0;
            exp          <= '0;
            sign         <= 1'b0;
            zero         <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            result       <= FP_ZERO;
            result_valid <= 1'b0;
        end else begin
            done <= 1'b0;
            if (done) busy <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    mag          <= data_in;
                    result_valid <= 1'b0;
                    state        <= LOAD;
                end
                LOAD: begin
                    sign  <= neg;
                    mag   <= abs_mag;
                    exp   <= FP_INT_EXP0;
                    zero  <= abs_mag == 32'h0;
                    busy  <= 1'b1;
                    state <= ((abs_mag == 32'h0) && ZERO_FAST) || abs_mag[31] ? ROUND : NORM;
                end
                NORM: begin
                    mag <= mag << 1;
                    exp <= exp - 8'd1;
                    // the exponent floor bounds a slow-path zero to 31 shifts
                    if (mag[30] || exp == 8'(FP_BIAS + 1)) state <= ROUND;
                end
                ROUND: begin
                    result       <= zero ? FP_ZERO : rounded;
                    done         <= 1'b1;
                    result_valid <= 1'b1;
                    state        <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fp_int_to_float.sv
// tb_fp_int_to_float: scoreboard bench over signed, unsigned and slow-zero converter instances.
module tb_fp_int_to_float;
    typedef struct {
        int          inst;
        logic [31:0] res;
        int          at_edge;
    } exp_t;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start_v [3];
    logic [31:0] data_v  [3];
    logic        busy_v  [3];
    logic        done_v  [3];
    logic [31:0] res_v   [3];
    logic        rv_v    [3];
    logic [31:0] prev_res [3];
    exp_t        sb [$];
    int          cyc = 0;
    int          nvec = 0;
    int          nerr = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    fp_int_to_float #(.SIGNED_IN(1'b1), .ZERO_FAST(1'b1)) u_s (
        .clk(clk), .reset(reset), .start(start_v[0]), .data_in(data_v[0]),
        .busy(busy_v[0]), .done(done_v[0]), .result(res_v[0]), .result_valid(rv_v[0]));
    fp_int_to_float #(.SIGNED_IN(1'b0), .ZERO_FAST(1'b1)) u_u (
        .clk(clk), .reset(reset), .start(start_v[1]), .data_in(data_v[1]),
        .busy(busy_v[1]), .done(done_v[1]), .result(res_v[1]), .result_valid(rv_v[1]));
    fp_int_to_float #(.SIGNED_IN(1'b1), .ZERO_FAST(1'b0)) u_z (
        .clk(clk), .reset(reset), .start(start_v[2]), .data_in(data_v[2]),
        .busy(busy_v[2]), .done(done_v[2]), .result(res_v[2]), .result_valid(rv_v[2]));
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        nvec++;
        if (got !== want) begin
            nerr++;
            $display("FAIL %s: got %h want %h (cycle %0d)", tag, got, want, cyc);
        end
    endtask
    task automatic model(input logic [31:0] v, input bit sgn, input bit zfast,
                         output logic [31:0] r, output int lat);
        logic [31:0] m;
        logic [63:0] f, rem, half;
        int          p, e, sh;
        bit          s;
        s = sgn && v[31];
        m = s ? -v : v;
        if (m == 32'h0) begin
            r = 32'h0;
            lat = zfast ? 2 : 33;
            return;
        end
        p = 0;
        for (int i = 0; i < 32; i++) if (m[i]) p = i;
        e = 127 + p;
        if (p <= 23) f = 64'(m) << (23 - p);
        else begin
            sh = p - 23;
            f = 64'(m) >> sh;
            rem = 64'(m) & ((64'd1 << sh) - 64'd1);
            half = 64'd1 << (sh - 1);
            if (rem > half || (rem == half && f[0])) f = f + 64'd1;
        end
        if (f[24]) begin
            f = f >> 1;
            e++;
        end
        r = {s, 8'(e), f[22:0]};
        lat = 31 - p + 2;
    endtask
    task automatic wait_empty();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (sb.size() != 0) begin
            check("done_timeout", 32'd0, 32'd1);
            sb.delete();
        end
    endtask
    task automatic convert(input int i, input logic [31:0] v, input logic [31:0] want, input bit b2b);
        logic [31:0] mr;
        int          lat;
        exp_t        e;
        model(v, i != 1, i != 2, mr, lat);
        if (!b2b) @(negedge clk);
        start_v[i] = 1'b1;
        data_v[i] = v;
        e.inst = i;
        e.res = want;
        e.at_edge = cyc + 1 + lat;
        sb.push_back(e);
        @(negedge clk);
        start_v[i] = 1'b0;
        check("rv_cleared", 32'(rv_v[i]), 32'd0);
        check("result_held", res_v[i], prev_res[i]);
        check("busy_low_accept", 32'(busy_v[i]), 32'd0);
        @(negedge clk);
        check("busy_high", 32'(busy_v[i]), 32'd1);
        wait_empty();
        prev_res[i] = want;
    endtask
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (!reset && done_v[i]) begin
                if (sb.size() == 0) check("spurious_done", 32'd1, 32'd0);
                else begin
                    check("inst", 32'(i), 32'(sb[0].inst));
                    check("result", res_v[i], sb[0].res);
                    check("latency", 32'(cyc), 32'(sb[0].at_edge));
                    check("rv_set", 32'(rv_v[i]), 32'd1);
                    check("busy_in_done", 32'(busy_v[i]), 32'd1);
                    void'(sb.pop_front());
                end
            end
        end
    end
    initial begin
        logic [31:0] v, r;
        int          lat;
        exp_t        e;
        for (int i = 0; i < 3; i++) begin
            start_v[i] = 1'b0;
            data_v[i] = 32'h0;
            prev_res[i] = 32'h0;
        end
        repeat (3) @(negedge clk);
        check("rst_result", res_v[0], 32'h0);
        check("rst_busy", 32'(busy_v[0]), 32'd0);
        check("rst_done", 32'(done_v[0]), 32'd0);
        check("rst_rv", 32'(rv_v[0]), 32'd0);
        reset = 1'b0;
        convert(0, 32'h00000001, 32'h3F800000, 0);
        convert(0, 32'hFFFFFFFF, 32'hBF800000, 0);
        convert(0, 32'h01000001, 32'h4B800000, 0);
        convert(0, 32'h01000003, 32'h4B800002, 1);
        convert(0, 32'h7FFFFFFF, 32'h4F000000, 1);
        convert(0, 32'h80000000, 32'hCF000000, 0);
        convert(0, 32'h00000000, 32'h00000000, 1);
        convert(1, 32'hFFFFFFFF, 32'h4F800000, 0);
        convert(1, 32'h80000000, 32'h4F000000, 1);
        convert(2, 32'h00000000, 32'h00000000, 0);
        convert(2, 32'h00000001, 32'h3F800000, 1);
        for (int k = 0; k < 16; k++) begin
            v = $urandom >> $urandom_range(31, 0);
            if (k[0]) v = -v;
            model(v, 1'b1, 1'b1, r, lat);
            convert(0, v, r, k[1]);
        end
        // a second start while busy must be dropped
        @(negedge clk);
        start_v[0] = 1'b1;
        data_v[0] = 32'h1;
        e.inst = 0;
        e.res = 32'h3F800000;
        e.at_edge = cyc + 34;
        sb.push_back(e);
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (4) @(negedge clk);
        start_v[0] = 1'b1;
        data_v[0] = 32'h5;
        @(negedge clk);
        start_v[0] = 1'b0;
        wait_empty();
        repeat (40) @(negedge clk);
        check("ignored_hold", res_v[0], 32'h3F800000);
        // reset mid-conversion aborts without done
        start_v[0] = 1'b1;
        data_v[0] = 32'h1;
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        #1;
        check("abort_result", res_v[0], 32'h0);
        check("abort_busy", 32'(busy_v[0]), 32'd0);
        check("abort_rv", 32'(rv_v[0]), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        check("abort_no_done", res_v[0], 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
